// File: rtl/tag_pkg.sv
// Shared definitions for the tag lookup controller: FSM encoding, entry
// field positions and address slicing helpers.
package tag_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_CMP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Entry field positions, counted down from the MSB of an entry, so that
  // the layout holds for any entry width:
  //   bit DWIDTH-1 = valid, bit DWIDTH-2 = dirty, remaining low bits = tag.
  localparam int VALID_FROM_TOP = 0;
  localparam int DIRTY_FROM_TOP = 1;

  // Index field of an {tag, index} address (low aw bits).
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int aw);
    return addr & ((32'd1 << aw) - 32'd1);
  endfunction

  // Tag field of an {tag, index} address (bits above the index).
  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int aw);
    return addr >> aw;
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl.sv
// Tag RAM sequencer for a direct-mapped cache. Clears the RAM after reset
// or flush, serves CPU lookups (hit/miss plus victim info), installs refill
// tags and marks lines dirty on write hits. Sole master of the tag RAM.
//
// Handshakes: a lookup transfers on a cycle where req_valid && req_ready;
// a fill transfers on a cycle where fill_valid && fill_ready. Both ready
// signals are combinational, are only ever high in IDLE, and never depend
// on the same-port valid except through the IDLE priority order
// flush_start > fill_valid > req_valid.
module tag_lookup_ctrl
  import tag_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       flush_start,
  output logic                       busy,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DWIDTH-2+AWIDTH-1:0] req_addr,
  input  logic                       req_wr,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic                       resp_victim_valid,
  output logic                       resp_victim_dirty,
  output logic [DWIDTH-3:0]          resp_victim_tag,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [DWIDTH-2+AWIDTH-1:0] fill_addr,
  input  logic                       fill_dirty,
  output logic [AWIDTH-1:0]          ram_addr,
  output logic [DWIDTH-1:0]          ram_din,
  output logic                       ram_we,
  input  logic [DWIDTH-1:0]          ram_dout
);

  localparam int DEPTH     = 1 << AWIDTH;
  localparam int TWIDTH    = DWIDTH - 2;
  localparam int VALID_BIT = DWIDTH - 1 - VALID_FROM_TOP;
  localparam int DIRTY_BIT = DWIDTH - 1 - DIRTY_FROM_TOP;
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  state_t              state;
  state_t              state_next;
  logic [AWIDTH-1:0]   clr_cnt;
  logic [AWIDTH-1:0]   cap_idx;
  logic [TWIDTH-1:0]   cap_tag;
  logic                cap_wr;
  logic                accept;
  logic                flush_go;
  logic                hit_now;

  logic [AWIDTH-1:0]   req_idx;
  logic [TWIDTH-1:0]   req_tag;
  logic [AWIDTH-1:0]   fill_idx;
  logic [TWIDTH-1:0]   fill_tag;

  assign req_idx  = AWIDTH'(idx_of(32'(req_addr), AWIDTH));
  assign req_tag  = TWIDTH'(tag_of(32'(req_addr), AWIDTH));
  assign fill_idx = AWIDTH'(idx_of(32'(fill_addr), AWIDTH));
  assign fill_tag = TWIDTH'(tag_of(32'(fill_addr), AWIDTH));

  // Compare the entry read for the captured index against the captured tag.
  assign hit_now = ram_dout[VALID_BIT] && (ram_dout[TWIDTH-1:0] == cap_tag);

  // State register and clear-walk counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + AWIDTH'(1);
      end else if (flush_go) begin
        clr_cnt <= '0;
      end
    end
  end

  // Next state and all RAM-side / ready outputs.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    req_ready  = 1'b0;
    fill_ready = 1'b0;
    accept     = 1'b0;
    flush_go   = 1'b0;
    case (state)
      ST_INIT: begin
        // Gated by rst_n so the RAM is never written while reset is held.
        ram_we   = rst_n;
        ram_addr = clr_cnt;
        if (clr_cnt == LAST_IDX) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_start) begin
          flush_go   = 1'b1;
          state_next = ST_INIT;
        end else if (fill_valid) begin
          fill_ready = 1'b1;
          ram_we     = 1'b1;
          ram_addr   = fill_idx;
          ram_din    = {1'b1, fill_dirty, fill_tag};
        end else begin
          req_ready = 1'b1;
          ram_addr  = req_idx;
          if (req_valid) begin
            accept     = 1'b1;
            state_next = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        ram_addr   = cap_idx;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        ram_addr = cap_idx;
        // Write hit on a clean line: set the dirty bit in place.
        if (resp_hit && cap_wr && !resp_victim_dirty) begin
          ram_we  = 1'b1;
          ram_din = {1'b1, 1'b1, cap_tag};
        end
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Capture the accepted request for the compare and write-back cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cap_idx <= '0;
      cap_tag <= '0;
      cap_wr  <= 1'b0;
    end else if (accept) begin
      cap_idx <= req_idx;
      cap_tag <= req_tag;
      cap_wr  <= req_wr;
    end
  end

  // Register the stored entry and the compare result; they drive the response.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid        <= 1'b0;
      resp_hit          <= 1'b0;
      resp_victim_valid <= 1'b0;
      resp_victim_dirty <= 1'b0;
      resp_victim_tag   <= '0;
    end else begin
      resp_valid <= (state == ST_CMP);
      if (state == ST_CMP) begin
        resp_hit          <= hit_now;
        resp_victim_valid <= ram_dout[VALID_BIT];
        resp_victim_dirty <= ram_dout[DIRTY_BIT];
        resp_victim_tag   <= ram_dout[TWIDTH-1:0];
      end
    end
  end

  // Busy tracks the clear walk, registered so it lines up with INIT cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b1;
    end else begin
      busy <= (state_next == ST_INIT);
    end
  end

endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
Controller that sequences a direct-mapped cache's single-port, synchronous-read tag RAM (AWIDTH index bits, DWIDTH-bit entries).
- Clears the RAM after reset or on a flush command.
- Serves CPU-side lookup requests, returning hit/miss and victim information.
- Writes refill tags from the refill engine.
- Sets the dirty bit on write hits.
- Sits between the cache front end and the tag RAM instance; it is the only master of that RAM.

Parameters:
- AWIDTH, 3: index width; DEPTH = 1 << AWIDTH entries (localparam).
- DWIDTH, 14: tag RAM entry width. Entry layout: bit DWIDTH-1 = valid, bit DWIDTH-2 = dirty, bits DWIDTH-3:0 = tag.
- TWIDTH, DWIDTH-2 (localparam): tag width.

Ports:
- clock, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- flush_start, in, 1: request to invalidate all entries.
- busy, out, 1: high during INIT/flush walk.
- req_valid, in, 1: lookup request valid.
- req_ready, out, 1: controller can accept a lookup.
- req_addr, in, TWIDTH+AWIDTH: {tag, index}.
- req_wr, in, 1: request is a write (sets dirty on hit).
- resp_valid, out, 1: one-cycle response pulse.
- resp_hit, out, 1: hit flag, qualified by resp_valid.
- resp_victim_valid, out, 1: stored entry was valid.
- resp_victim_dirty, out, 1: stored entry was dirty.
- resp_victim_tag, out, TWIDTH: stored tag.
- fill_valid, in, 1: refill tag write request.
- fill_ready, out, 1: fill accepted this cycle.
- fill_addr, in, TWIDTH+AWIDTH: {tag, index} to install.
- fill_dirty, in, 1: dirty value to install.
- ram_addr, out, AWIDTH: tag RAM address.
- ram_din, out, DWIDTH: tag RAM write data.
- ram_we, out, 1: tag RAM write enable.
- ram_dout, in, DWIDTH: tag RAM read data (valid one cycle after address).

Behaviour:
- States:
  - INIT: clear walk.
  - IDLE
  - CMP: RAM data available; compare.
  - RESP: response cycle and optional dirty write.
- Reset (rst_n low, asynchronous):
  - State = INIT; clear counter = 0.
  - resp_valid = 0, resp_hit = 0, victim outputs = 0, busy = 1.
  - req_ready = 0, fill_ready = 0, ram_we = 0.
  - Any in-flight request is dropped with no response.
- INIT:
  - Each cycle: ram_we = 1, ram_addr = counter, ram_din = 0; counter increments.
  - After writing index DEPTH-1, go to IDLE. INIT takes exactly DEPTH cycles.
  - Counter wraps to 0 on exit; busy deasserts on the first IDLE cycle.
- IDLE priority: flush_start > fill_valid > req_valid.
  - flush_start: go to INIT, counter = 0. Fills and requests are not accepted that cycle.
  - fill_valid (no flush): fill_ready = 1 combinationally; same cycle ram_we = 1, ram_addr = fill index, ram_din = {1, fill_dirty, fill tag}. Stay in IDLE.
  - req_ready = 1 in IDLE only when flush_start = 0 and fill_valid = 0.
  - On req_valid & req_ready: ram_addr = req index (read), capture req_addr and req_wr, go to CMP.
  - Outside IDLE: req_ready = 0 and fill_ready = 0.
- CMP (one cycle after accept):
  - Register entry = ram_dout.
  - hit = valid & (stored tag == captured tag).
  - Go to RESP.
- RESP (two cycles after accept):
  - resp_valid = 1 for exactly one cycle, with resp_hit and victim fields from the registered entry.
  - If hit & req_wr & !dirty: ram_we = 1 at the captured index, ram_din = {1, 1, tag}.
  - Next state IDLE; the next request can be accepted the cycle after RESP.
- Throughput: one lookup per 3 cycles.
- Miss: no RAM write. The refill engine later installs the line via the fill port.
- Fill racing a lookup to the same index: impossible by construction, since fills are only accepted in IDLE.
- flush_start outside IDLE is ignored; requesters must hold it until busy rises.
- All outputs except ram_addr/ram_din/ram_we/req_ready/fill_ready are registered.

Decomposition:
- Shared package tag_pkg holds:
  - State encoding: INIT, IDLE, CMP, RESP.
  - Entry field bit positions: VALID_BIT, DIRTY_BIT.
  - Helpers: idx_of() and tag_of() address slicing.
- No sub-module is needed. The tag RAM is instantiated alongside this block at the parent level, not inside it.

Test Plan:
1. Reset release, AWIDTH=3 → busy high 8 cycles; ram_we = 1 with ram_addr 0..7 and ram_din = 0; req_ready rises on cycle 9.
2. Read of addr tag 0x0A5, index 3 after init → resp_valid exactly 2 cycles after accept; resp_hit = 0, victim_valid = 0, no ram_we.
3. Fill tag 0x0A5, index 3, dirty 0, then write request to the same address → resp_hit = 1, victim_dirty = 0; ram_we in the RESP cycle with ram_din = 0x30A5.
4. Request tag 0x123, index 3 → resp_hit = 0, victim_valid = 1, victim_dirty = 1, victim_tag = 0x0A5.
5. flush_start, fill_valid and req_valid all high in the same IDLE cycle → flush wins: fill_ready = 0, req_ready = 0, 8-cycle walk; a subsequent lookup of index 3 misses.
6. rst_n pulsed low during CMP → no resp_valid; busy = 1; full INIT walk restarts at index 0.
